branch_sequencer: RTL and testbench

Sequences the shared 32-bit compare unit for branch and jump resolution in the CPU core. Accepts one decoded control-transfer op at a time over a valid/ready handshake and drives the compare unit's operands and operation from registered state. Produces taken/next-PC/link results over a second valid/ready handshake toward fetch/writeback, and supports a synchronous pipeline flush.

---
 rtl/branch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Branch/jump resolution sequencer: owns the shared compare unit for one control-transfer
// op at a time and returns taken / next-PC / link over a valid/ready result channel.
`timescale 1ns/1ps
module branch_sequencer #(
  parameter int IALIGN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic        flush,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  output logic [2:0]  cmp_op,
  input  logic        cmp_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic        res_misaligned,
  output logic        res_illegal,
  output logic [31:0] res_next_pc,
  output logic [31:0] res_link
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;

  state_t      r_state;
  logic [1:0]  r_kind;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [31:0] r_cmp_a;
  logic [31:0] r_cmp_b;
  logic [2:0]  r_cmp_op;
  logic        r_res_valid;
  logic        r_res_taken;
  logic        r_res_misaligned;
  logic        r_res_illegal;
  logic [31:0] r_res_next_pc;
  logic [31:0] r_res_link;

  logic        w_accept;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_illegal;
  logic        w_taken;
  logic        w_misaligned;

  // Ready is held low through reset so nothing is accepted before the FSM is known-idle.
  assign in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));
  assign w_accept = in_valid && in_ready;

  assign cmp_a          = r_cmp_a;
  assign cmp_b          = r_cmp_b;
  assign cmp_op         = r_cmp_op;
  assign res_valid      = r_res_valid;
  assign res_taken      = r_res_taken;
  assign res_misaligned = r_res_misaligned;
  assign res_illegal    = r_res_illegal;
  assign res_next_pc    = r_res_next_pc;
  assign res_link       = r_res_link;

  // Resolve the captured op; cmp_result is only meaningful while in EVAL.
  always_comb begin
    w_pc4        = r_pc + 32'd4;
    w_target     = r_pc + r_imm;
    w_illegal    = 1'b0;
    w_taken      = 1'b0;
    w_misaligned = 1'b0;
    case (r_kind)
      KIND_BRANCH: begin
        if ((r_cmp_op == 3'b010) || (r_cmp_op == 3'b011)) begin
          w_illegal = 1'b1;
        end else begin
          w_taken = cmp_result;
        end
      end
      KIND_JAL: begin
        w_taken = 1'b1;
      end
      KIND_JALR: begin
        w_target = (r_cmp_a + r_imm) & 32'hFFFF_FFFE;
        w_taken  = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    if (IALIGN == 32'sd32) begin
      w_misaligned = w_taken && w_target[1];
    end else begin
      w_misaligned = 1'b0;
    end
  end

  // Control FSM with capture, result registers and flush handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_kind           <= 2'b00;
      r_pc             <= 32'd0;
      r_imm            <= 32'd0;
      r_cmp_a          <= 32'd0;
      r_cmp_b          <= 32'd0;
      r_cmp_op         <= 3'd0;
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_misaligned <= 1'b0;
      r_res_illegal    <= 1'b0;
      r_res_next_pc    <= 32'd0;
      r_res_link       <= 32'd0;
    end else if (flush) begin
      // Flush drops any op offered this cycle and withdraws a pending result.
      r_state     <= S_IDLE;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_kind   <= in_kind;
        r_pc     <= in_pc;
        r_imm    <= in_imm;
        r_cmp_a  <= in_rs1;
        r_cmp_b  <= in_rs2;
        r_cmp_op <= in_funct3;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_EVAL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EVAL: begin
          r_res_taken      <= w_taken;
          r_res_illegal    <= w_illegal;
          r_res_misaligned <= w_misaligned;
          r_res_next_pc    <= w_taken ? w_target : w_pc4;
          r_res_link       <= w_pc4;
          r_res_valid      <= 1'b1;
          r_state          <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_accept ? S_EVAL : S_IDLE;
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: two instances (IALIGN 32 and 16) share stimulus,
// each with a behavioural model of the external compare unit.
`timescale 1ns/1ps
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_kind = 2'b00;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_pc = 32'd0, in_rs1 = 32'd0, in_rs2 = 32'd0, in_imm = 32'd0;
  logic        flush = 1'b0;
  logic        res_ready = 1'b0;

  logic        in_ready, cmp_result, res_valid, res_taken, res_misaligned, res_illegal;
  logic [31:0] cmp_a, cmp_b, res_next_pc, res_link;
  logic [2:0]  cmp_op;

  logic        in_ready16, cmp_result16, res_valid16, res_taken16, res_misaligned16, res_illegal16;
  logic [31:0] cmp_a16, cmp_b16, res_next_pc16, res_link16;
  logic [2:0]  cmp_op16;

  int n_vec  = 0;
  int n_fail = 0;
  bit ok;

  always #5 clk = ~clk;

  branch_sequencer #(.IALIGN(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_result(cmp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_misaligned(res_misaligned), .res_illegal(res_illegal),
    .res_next_pc(res_next_pc), .res_link(res_link)
  );

  branch_sequencer #(.IALIGN(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush), .cmp_a(cmp_a16), .cmp_b(cmp_b16), .cmp_op(cmp_op16), .cmp_result(cmp_result16),
    .res_valid(res_valid16), .res_ready(res_ready), .res_taken(res_taken16),
    .res_misaligned(res_misaligned16), .res_illegal(res_illegal16),
    .res_next_pc(res_next_pc16), .res_link(res_link16)
  );

  // Compare unit model; undefined codes answer 1 so illegal ops must force taken low.
  function automatic logic cmp_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  assign cmp_result   = cmp_model(cmp_a, cmp_b, cmp_op);
  assign cmp_result16 = cmp_model(cmp_a16, cmp_b16, cmp_op16);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    in_kind = k; in_funct3 = f3; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
  endtask

  // Offers an op and returns one cycle after the accepting edge (DUT then in EVAL).
  task automatic present_op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            output bit accepted);
    set_op(k, f3, pc, a, b, imm);
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_vec++; if (res_taken !== 1'b0 || res_illegal !== 1'b0 || res_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b%b want 000", res_taken, res_illegal, res_misaligned); end
    n_vec++; if (res_next_pc !== 32'd0 || res_link !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h/%h want 0/0", res_next_pc, res_link); end
    n_vec++; if (cmp_a !== 32'd0 || cmp_b !== 32'd0 || cmp_op !== 3'd0) begin n_fail++; $display("FAIL rst_cmp: got %h/%h/%h want 0", cmp_a, cmp_b, cmp_op); end
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_beq();
    present_op(2'b00, 3'b000, 32'h100, 32'h1234, 32'h1234, 32'h20, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL beq_accept: got timeout want handshake"); end
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL beq_early_valid: got %b want 0", res_valid); end
    n_vec++; if (cmp_a !== 32'h1234 || cmp_b !== 32'h1234 || cmp_op !== 3'b000) begin n_fail++; $display("FAIL beq_cmp_drive: got %h/%h/%h want 1234/1234/0", cmp_a, cmp_b, cmp_op); end
    tick();
    n_vec++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %b want 1", res_valid); end
    n_vec++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", res_taken); end
    n_vec++; if (res_next_pc !== 32'h120) begin n_fail++; $display("FAIL beq_next_pc: got %h want 00000120", res_next_pc); end
    n_vec++; if (res_link !== 32'h104) begin n_fail++; $display("FAIL beq_link: got %h want 00000104", res_link); end
    n_vec++; if (res_illegal !== 1'b0 || res_misaligned !== 1'b0) begin n_fail++; $display("FAIL beq_flags: got %b%b want 00", res_illegal, res_misaligned); end
    drain();
    n_vec++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_release: got valid %b ready %b want 0 1", res_valid, in_ready); end
  endtask

  task automatic test_signed_unsigned();
    present_op(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, ok);
    tick();
    n_vec++; if (!ok || res_valid !== 1'b1) begin n_fail++; $display("FAIL blt_valid: got %b want 1", res_valid); end
    n_vec++; if (res_taken !== 1'b1 || res_next_pc !== 32'h240) begin n_fail++; $display("FAIL blt_taken: got %b %h want 1 00000240", res_taken, res_next_pc); end
    drain();
    present_op(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, ok);
    tick();
    n_vec++; if (!ok || res_valid !== 1'b1) begin n_fail++; $display("FAIL bltu_valid: got %b want 1", res_valid); end
    n_vec++; if (res_taken !== 1'b0 || res_next_pc !== 32'h204) begin n_fail++; $display("FAIL bltu_not_taken: got %b %h want 0 00000204", res_taken, res_next_pc); end
    drain();
  endtask

  task automatic test_jumps();
    present_op(2'b10, 3'b000, 32'h300, 32'h1001, 32'h0, 32'h2, ok);
    tick();
    n_vec++; if (!ok || res_valid !== 1'b1 || res_valid16 !== 1'b1) begin n_fail++; $display("FAIL jalr_valid: got %b/%b want 1/1", res_valid, res_valid16); end
    n_vec++; if (res_taken !== 1'b1 || res_next_pc !== 32'h1002) begin n_fail++; $display("FAIL jalr_target: got %b %h want 1 00001002", res_taken, res_next_pc); end
    n_vec++; if (res_misaligned !== 1'b1) begin n_fail++; $display("FAIL jalr_misaligned32: got %b want 1", res_misaligned); end
    n_vec++; if (res_misaligned16 !== 1'b0 || res_next_pc16 !== 32'h1002) begin n_fail++; $display("FAIL jalr_misaligned16: got %b %h want 0 00001002", res_misaligned16, res_next_pc16); end
    n_vec++; if (res_link !== 32'h304) begin n_fail++; $display("FAIL jalr_link: got %h want 00000304", res_link); end
    drain();
    present_op(2'b01, 3'b000, 32'hFFFF_FFFC, 32'h1, 32'h2, 32'h8, ok);
    tick();
    n_vec++; if (!ok || res_taken !== 1'b1 || res_next_pc !== 32'h4) begin n_fail++; $display("FAIL jal_wrap_target: got %b %h want 1 00000004", res_taken, res_next_pc); end
    n_vec++; if (res_link !== 32'h0 || res_misaligned !== 1'b0) begin n_fail++; $display("FAIL jal_wrap_link: got %h %b want 00000000 0", res_link, res_misaligned); end
    drain();
  endtask

  task automatic test_back_to_back();
    present_op(2'b00, 3'b001, 32'h500, 32'h5, 32'h6, 32'h100, ok);
    tick();
    set_op(2'b00, 3'b101, 32'h700, 32'h3, 32'h7, 32'h80);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (res_valid !== 1'b1 || res_next_pc !== 32'h600 || res_taken !== 1'b1 || res_link !== 32'h504) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b %b %h %h want 1 1 00000600 00000504", i, res_valid, res_taken, res_next_pc, res_link); end
      n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    res_ready = 1'b0;
    n_vec++; if (res_valid !== 1'b0 || cmp_a !== 32'h3 || cmp_op !== 3'b101) begin n_fail++; $display("FAIL b2b_eval: got %b %h %h want 0 00000003 5", res_valid, cmp_a, cmp_op); end
    tick();
    n_vec++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_next_pc !== 32'h704) begin n_fail++; $display("FAIL b2b_second: got %b %b %h want 1 0 00000704", res_valid, res_taken, res_next_pc); end
    drain();
  endtask

  task automatic test_flush();
    present_op(2'b01, 3'b000, 32'h800, 32'h0, 32'h0, 32'h20, ok);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (!ok || res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_eval: got valid %b ready %b want 0 1", res_valid, in_ready); end
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_eval_late: got %b want 0", res_valid); end
    present_op(2'b00, 3'b111, 32'h900, 32'h9, 32'h9, 32'h10, ok);
    tick();
    n_vec++; if (!ok || res_valid !== 1'b1 || res_next_pc !== 32'h910) begin n_fail++; $display("FAIL flush_pre_hold: got %b %h want 1 00000910", res_valid, res_next_pc); end
    set_op(2'b01, 3'b000, 32'hC00, 32'h77, 32'h0, 32'h40);
    in_valid = 1'b1;
    res_ready = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0; res_ready = 1'b0; flush = 1'b0;
    n_vec++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_hold: got valid %b ready %b want 0 1", res_valid, in_ready); end
    n_vec++; if (cmp_a !== 32'h9) begin n_fail++; $display("FAIL flush_drop_capture: got %h want 00000009", cmp_a); end
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_result: got %b want 0", res_valid); end
  endtask

  task automatic test_illegal();
    present_op(2'b00, 3'b010, 32'hA00, 32'h5, 32'h5, 32'h40, ok);
    tick();
    n_vec++; if (!ok || res_illegal !== 1'b1 || res_taken !== 1'b0 || res_next_pc !== 32'hA04) begin n_fail++; $display("FAIL illegal_f3_010: got %b %b %h want 1 0 00000a04", res_illegal, res_taken, res_next_pc); end
    drain();
    present_op(2'b00, 3'b011, 32'hA80, 32'h5, 32'h6, 32'h40, ok);
    tick();
    n_vec++; if (!ok || res_illegal !== 1'b1 || res_taken !== 1'b0 || res_next_pc !== 32'hA84) begin n_fail++; $display("FAIL illegal_f3_011: got %b %b %h want 1 0 00000a84", res_illegal, res_taken, res_next_pc); end
    drain();
    present_op(2'b11, 3'b000, 32'hB00, 32'h1, 32'h1, 32'h40, ok);
    tick();
    n_vec++; if (!ok || res_illegal !== 1'b1 || res_taken !== 1'b0 || res_next_pc !== 32'hB04 || res_link !== 32'hB04) begin n_fail++; $display("FAIL illegal_kind11: got %b %b %h %h want 1 0 00000b04 00000b04", res_illegal, res_taken, res_next_pc, res_link); end
    drain();
  endtask

  task automatic test_reset_over_flush();
    present_op(2'b01, 3'b000, 32'hD00, 32'h0, 32'h0, 32'h8, ok);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    n_vec++; if (!ok || res_valid !== 1'b0 || res_next_pc !== 32'd0 || cmp_a !== 32'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b %h %h %b want 0 0 0 0", res_valid, res_next_pc, cmp_a, in_ready); end
    rst = 1'b0; flush = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jumps();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_over_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
